// File: rtl/divider_reconfig_ctrl.sv
// Sequences a run-time PLL feedback divider ratio change: freeze on div_clk fall, load N, settle, re-enable, await lock.
// Latency: enable drops 1 cycle after the detected fall, low SETTLE_CYCLES+1 cycles, done after LOCK_COUNT locked cycles.
// Backpressure: cfg_ready is low for the whole sequence; a requester must hold cfg_valid until it sees cfg_ready.
module divider_reconfig_ctrl #(
    parameter int N_SIZE        = 8,
    parameter int N_DEFAULT     = 8,
    parameter int SETTLE_CYCLES = 4,
    parameter int LOCK_COUNT    = 16,
    parameter int LOCK_TIMEOUT  = 1024,
    parameter int EDGE_TIMEOUT  = 512
) (
    input  logic              clk_in,
    input  logic              rst,
    input  logic              cfg_valid,
    input  logic [N_SIZE-1:0] cfg_n,
    output logic              cfg_ready,
    input  logic              div_clk,
    input  logic              lock,
    output logic [N_SIZE-1:0] div_n,
    output logic              div_enable,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code
);

    // One shared timer serves the edge wait, the settle hold and the lock timeout.
    localparam int TMR_MAX0 = (EDGE_TIMEOUT > LOCK_TIMEOUT) ? EDGE_TIMEOUT : LOCK_TIMEOUT;
    localparam int TMR_MAX  = (TMR_MAX0 > SETTLE_CYCLES) ? TMR_MAX0 : SETTLE_CYCLES;
    localparam int TMR_W    = $clog2(TMR_MAX + 1);
    localparam int LCK_W    = $clog2(LOCK_COUNT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_EDGE,
        S_FREEZE,
        S_SETTLE,
        S_LOCK_WAIT
    } state_t;

    state_t            state, state_nxt;
    logic              div_clk_q;
    logic [N_SIZE-1:0] pending_n, pending_n_nxt;
    logic [TMR_W-1:0]  tmr, tmr_nxt;
    logic [LCK_W-1:0]  lock_cnt, lock_cnt_nxt;
    logic [N_SIZE-1:0] div_n_nxt;
    logic              div_enable_nxt;
    logic              cfg_ready_nxt;
    logic              busy_nxt;
    logic              done_nxt;
    logic              err_nxt;
    logic [1:0]        err_code_nxt;
    logic              div_fall;

    assign div_fall = div_clk_q & ~div_clk;

    // State, timers and all registered outputs; reset aborts any sequence in flight.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            state      <= S_IDLE;
            div_clk_q  <= 1'b0;
            pending_n  <= '0;
            tmr        <= '0;
            lock_cnt   <= '0;
            div_n      <= N_SIZE'(N_DEFAULT);
            div_enable <= 1'b1;
            cfg_ready  <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            err_code   <= 2'b00;
        end else begin
            state      <= state_nxt;
            div_clk_q  <= div_clk;
            pending_n  <= pending_n_nxt;
            tmr        <= tmr_nxt;
            lock_cnt   <= lock_cnt_nxt;
            div_n      <= div_n_nxt;
            div_enable <= div_enable_nxt;
            cfg_ready  <= cfg_ready_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
            err        <= err_nxt;
            err_code   <= err_code_nxt;
        end
    end

    // Next-state and next-output decode; pulses default low, everything else holds.
    always_comb begin
        state_nxt      = state;
        pending_n_nxt  = pending_n;
        tmr_nxt        = tmr;
        lock_cnt_nxt   = lock_cnt;
        div_n_nxt      = div_n;
        div_enable_nxt = div_enable;
        cfg_ready_nxt  = cfg_ready;
        busy_nxt       = busy;
        done_nxt       = 1'b0;
        err_nxt        = 1'b0;
        err_code_nxt   = err_code;
        case (state)
            S_IDLE: begin
                if (cfg_valid && cfg_ready) begin
                    err_code_nxt = 2'b00;
                    if (cfg_n < N_SIZE'(2)) begin
                        // Ratios below 2 cannot be produced by the divider.
                        err_nxt      = 1'b1;
                        err_code_nxt = 2'b01;
                    end else begin
                        pending_n_nxt = cfg_n;
                        tmr_nxt       = '0;
                        cfg_ready_nxt = 1'b0;
                        busy_nxt      = 1'b1;
                        state_nxt     = S_WAIT_EDGE;
                    end
                end
            end
            S_WAIT_EDGE: begin
                // Freezing just after a fall keeps the divided clock from glitching;
                // if the divider never toggles, apply anyway after the timeout.
                if (div_fall || tmr == TMR_W'(EDGE_TIMEOUT - 1)) begin
                    div_enable_nxt = 1'b0;
                    tmr_nxt        = '0;
                    state_nxt      = S_FREEZE;
                end else begin
                    tmr_nxt = tmr + 1'b1;
                end
            end
            S_FREEZE: begin
                div_n_nxt = pending_n;
                tmr_nxt   = '0;
                state_nxt = S_SETTLE;
            end
            S_SETTLE: begin
                if (tmr == TMR_W'(SETTLE_CYCLES - 1)) begin
                    div_enable_nxt = 1'b1;
                    tmr_nxt        = '0;
                    lock_cnt_nxt   = '0;
                    state_nxt      = S_LOCK_WAIT;
                end else begin
                    tmr_nxt = tmr + 1'b1;
                end
            end
            S_LOCK_WAIT: begin
                lock_cnt_nxt = lock ? lock_cnt + 1'b1 : '0;
                // Lock success wins over a timeout landing on the same cycle.
                if (lock && lock_cnt == LCK_W'(LOCK_COUNT - 1)) begin
                    done_nxt      = 1'b1;
                    cfg_ready_nxt = 1'b1;
                    busy_nxt      = 1'b0;
                    state_nxt     = S_IDLE;
                end else if (tmr == TMR_W'(LOCK_TIMEOUT - 1)) begin
                    err_nxt       = 1'b1;
                    err_code_nxt  = 2'b10;
                    cfg_ready_nxt = 1'b1;
                    busy_nxt      = 1'b0;
                    state_nxt     = S_IDLE;
                end else begin
                    tmr_nxt = tmr + 1'b1;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_divider_reconfig_ctrl.sv
// Directed bench for divider_reconfig_ctrl with a behavioural divider and a response scoreboard.
// Latency: checks freeze/settle/lock timing in cycles relative to the observed div_clk fall and re-enable.
// Backpressure: verifies cfg_ready stays low while a sequence is in flight.
module tb_divider_reconfig_ctrl;

    logic       clk_in = 1'b0;
    logic       rst = 1'b1;
    logic       cfg_valid = 1'b0;
    logic [7:0] cfg_n = 8'd0;
    logic       cfg_ready;
    logic       div_clk;
    logic       lock = 1'b0;
    logic [7:0] div_n;
    logic       div_enable;
    logic       busy;
    logic       done;
    logic       err;
    logic [1:0] err_code;

    typedef struct packed {
        logic       is_err;
        logic [1:0] code;
        logic [7:0] n;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   fails = 0;
    logic last_s = 1'b0;
    logic hold_div = 1'b0;

    // Behavioural divider: counts 0..n-1, high for the first n/2 counts, frozen low when disabled.
    logic [7:0] mcnt = 8'd0;
    logic [7:0] mnext;
    logic       mclk = 1'b0;
    assign mnext   = (mcnt >= div_n - 8'd1) ? 8'd0 : mcnt + 8'd1;
    assign div_clk = hold_div ? 1'b0 : mclk;

    always #5 clk_in = ~clk_in;

    // Divider model state update.
    always @(posedge clk_in) begin
        if (rst || !div_enable) begin
            mcnt <= 8'd0;
            mclk <= 1'b0;
        end else begin
            mcnt <= mnext;
            mclk <= (mnext < (div_n >> 1));
        end
    end

    divider_reconfig_ctrl dut (
        .clk_in    (clk_in),
        .rst       (rst),
        .cfg_valid (cfg_valid),
        .cfg_n     (cfg_n),
        .cfg_ready (cfg_ready),
        .div_clk   (div_clk),
        .lock      (lock),
        .div_n     (div_n),
        .div_enable(div_enable),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .err_code  (err_code)
    );

    task automatic tick();
        last_s = div_clk;
        @(posedge clk_in);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare the pulse currently on done/err against the oldest scoreboard entry.
    task automatic check_resp(input string tag);
        exp_t e;
        check({tag, "_pulse"}, {31'b0, done | err}, 32'd1);
        check({tag, "_not_both"}, {31'b0, done & err}, 32'd0);
        if ((done || err) && sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_done"}, {31'b0, done}, {31'b0, ~e.is_err});
            check({tag, "_err"}, {31'b0, err}, {31'b0, e.is_err});
            check({tag, "_code"}, {30'b0, err_code}, {30'b0, e.code});
            check({tag, "_div_n"}, {24'b0, div_n}, {24'b0, e.n});
            check({tag, "_ready"}, {31'b0, cfg_ready}, 32'd1);
            check({tag, "_busy"}, {31'b0, busy}, 32'd0);
            check({tag, "_enable"}, {31'b0, div_enable}, 32'd1);
        end
    endtask

    // Issue one legal request and trace the sequence; cycle indices count from the accept.
    task automatic run_req(input string tag, input logic [7:0] n, input int lmode,
                           output int fall_at, output int low_first, output int low_cnt,
                           output int reen, output int endc);
        int cyc;
        fall_at = -1; low_first = -1; low_cnt = 0; reen = -1; cyc = 0;
        lock = 1'b0;
        cfg_n = n;
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        check({tag, "_acc_busy"}, {31'b0, busy}, 32'd1);
        check({tag, "_acc_ready"}, {31'b0, cfg_ready}, 32'd0);
        while (!(done || err) && cyc < 3000) begin
            if (fall_at < 0 && last_s && !div_clk) fall_at = cyc;
            if (!div_enable) begin
                if (low_first < 0) low_first = cyc;
                low_cnt++;
            end else if (low_first >= 0 && reen < 0) begin
                reen = cyc;
            end
            if (reen >= 0) lock = (lmode == 0) ? 1'b1 : (((cyc - reen) / 10) % 2 == 0);
            tick();
            cyc++;
        end
        endc = cyc;
        check_resp(tag);
        lock = 1'b0;
    endtask

    initial begin
        int fa, lf, lc, re, ec, c;

        // Reset held two cycles.
        rst = 1'b1;
        tick();
        tick();
        check("rst_div_n", {24'b0, div_n}, 32'd8);
        check("rst_enable", {31'b0, div_enable}, 32'd1);
        check("rst_ready", {31'b0, cfg_ready}, 32'd1);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_err", {31'b0, err}, 32'd0);
        check("rst_code", {30'b0, err_code}, 32'd0);
        rst = 1'b0;
        tick();
        tick();

        // Normal reconfiguration 8 -> 12 with lock asserted after re-enable.
        sb.push_back('{is_err: 1'b0, code: 2'b00, n: 8'd12});
        run_req("t2", 8'd12, 0, fa, lf, lc, re, ec);
        check("t2_fall_seen", {31'b0, fa >= 0}, 32'd1);
        check("t2_low_after_fall", lf, fa + 1);
        check("t2_low_len", lc, 32'd5);
        check("t2_done_delay", ec - re, 32'd16);
        tick();
        check("t2_done_1cyc", {31'b0, done}, 32'd0);

        // Illegal ratios 1 and 0.
        for (int k = 1; k >= 0; k--) begin
            sb.push_back('{is_err: 1'b1, code: 2'b01, n: 8'd12});
            cfg_n = 8'(k);
            cfg_valid = 1'b1;
            tick();
            cfg_valid = 1'b0;
            check_resp($sformatf("t3_n%0d", k));
            tick();
            check("t3_err_1cyc", {31'b0, err}, 32'd0);
            check("t3_code_held", {30'b0, err_code}, 32'd1);
            check("t3_enable", {31'b0, div_enable}, 32'd1);
            check("t3_idle", {31'b0, busy}, 32'd0);
        end

        // Lock toggling every 10 cycles never reaches 16 in a row: lock timeout.
        sb.push_back('{is_err: 1'b1, code: 2'b10, n: 8'd10});
        run_req("t4", 8'd10, 1, fa, lf, lc, re, ec);
        check("t4_timeout_len", ec - re, 32'd1024);
        tick();
        check("t4_code_held", {30'b0, err_code}, 32'd2);

        // Divider output stuck low: forced apply after the edge timeout.
        hold_div = 1'b1;
        tick();
        tick();
        sb.push_back('{is_err: 1'b0, code: 2'b00, n: 8'd6});
        run_req("t5", 8'd6, 0, fa, lf, lc, re, ec);
        check("t5_no_fall", fa, 32'hffff_ffff);
        check("t5_forced_at", lf, 32'd512);
        check("t5_low_len", lc, 32'd5);
        check("t5_done_delay", ec - re, 32'd16);
        hold_div = 1'b0;
        tick();

        // Reset during SETTLE while a second request is held on cfg_valid.
        cfg_n = 8'd20;
        cfg_valid = 1'b1;
        tick();
        cfg_n = 8'd30;
        c = 0;
        while (div_n != 8'd20 && c < 600) begin
            tick();
            c++;
        end
        check("t6_loaded", {24'b0, div_n}, 32'd20);
        check("t6_enable_low", {31'b0, div_enable}, 32'd0);
        check("t6_ready_busy", {31'b0, cfg_ready}, 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        cfg_valid = 1'b0;
        check("t6_div_n", {24'b0, div_n}, 32'd8);
        check("t6_enable", {31'b0, div_enable}, 32'd1);
        check("t6_busy", {31'b0, busy}, 32'd0);
        check("t6_ready", {31'b0, cfg_ready}, 32'd1);
        tick();
        check("t6_stay_idle", {31'b0, busy}, 32'd0);
        check("t6_no_pulse", {31'b0, done | err}, 32'd0);

        check("sb_empty", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
